// File: rtl/risc_sequencer.sv
// rtl/risc_sequencer.sv - 8-state fetch/execute instruction-cycle controller
// Moore strobes decoded from the current state plus the opcode/zero latched on S2->S3.
module risc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             ir_ena,
  output logic             rd,
  output logic             wr,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_acc,
  output logic             datactl_ena,
  output logic             halt,
  output logic [3:0]       phase,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] ST_S0     = 4'd0;
  localparam logic [3:0] ST_S1     = 4'd1;
  localparam logic [3:0] ST_S2     = 4'd2;
  localparam logic [3:0] ST_S3     = 4'd3;
  localparam logic [3:0] ST_S4     = 4'd4;
  localparam logic [3:0] ST_S5     = 4'd5;
  localparam logic [3:0] ST_S6     = 4'd6;
  localparam logic [3:0] ST_S7     = 4'd7;
  localparam logic [3:0] ST_IDLE   = 4'd8;
  localparam logic [3:0] ST_HALTED = 4'd9;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [2:0]       r_op_q;
  logic             r_zero_q;
  logic [CNT_W-1:0] r_cnt;

  logic w_aluop;
  logic w_skz_taken;
  logic w_jmp;
  logic w_sto;

  assign w_aluop     = (r_op_q >= 3'b010) && (r_op_q <= 3'b101);
  assign w_skz_taken = (r_op_q == OP_SKZ) && r_zero_q;
  assign w_jmp       = (r_op_q == OP_JMP);
  assign w_sto       = (r_op_q == OP_STO);

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Decode inputs are captured once per instruction so later opcode/zero changes are ignored.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_op_q   <= OP_HLT;
      r_zero_q <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (r_state == ST_S2) begin
        r_op_q   <= opcode;
        r_zero_q <= zero;
      end
      if (r_state == ST_S7) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_next = run ? ST_S0 : ST_IDLE;
      ST_S0:     w_next = ST_S1;
      ST_S1:     w_next = ST_S2;
      ST_S2:     w_next = ST_S3;
      ST_S3:     w_next = (r_op_q == OP_HLT) ? ST_HALTED : ST_S4;
      ST_S4:     w_next = ST_S5;
      ST_S5:     w_next = ST_S6;
      ST_S6:     w_next = ST_S7;
      ST_S7:     w_next = run ? ST_S0 : ST_IDLE;
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ir_ena      = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    case (r_state)
      ST_S0, ST_S1: begin
        ir_ena = 1'b1;
        rd     = 1'b1;
        inc_pc = 1'b1;
      end
      ST_S4: begin
        rd          = w_aluop;
        load_pc     = w_jmp;
        datactl_ena = w_sto;
      end
      ST_S5: begin
        rd          = w_aluop;
        load_acc    = w_aluop;
        load_pc     = w_jmp;
        inc_pc      = w_jmp || w_skz_taken;
        wr          = w_sto;
        datactl_ena = w_sto;
      end
      ST_S6: begin
        rd          = w_aluop;
        datactl_ena = w_sto;
      end
      ST_S7:     inc_pc = w_skz_taken;
      ST_HALTED: halt   = 1'b1;
      default: ;
    endcase
  end

  assign phase     = r_state;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_risc_sequencer.sv
// tb/tb_risc_sequencer.sv - scoreboard bench for risc_sequencer
// Stimulus pushes per-cycle expected outputs from a reference model; a monitor pops and compares.
module tb_risc_sequencer;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       ir_ena, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;
  logic [3:0] phase;
  logic [3:0] instr_cnt;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q[$];

  // model: mpos 0..7 = step within instruction, 8 = idle, 9 = halted
  int         mpos = 8;
  logic [2:0] mop = 3'b000;
  logic       mz = 1'b0;
  logic [3:0] mcnt = 4'd0;
  logic       stim_done = 1'b0;

  risc_sequencer #(.CNT_W(4)) dut (
    .clk1(clk1), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
    .ir_ena(ir_ena), .rd(rd), .wr(wr), .inc_pc(inc_pc), .load_pc(load_pc),
    .load_acc(load_acc), .datactl_ena(datactl_ena), .halt(halt),
    .phase(phase), .instr_cnt(instr_cnt)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [15:0] exp_vec(int pos, logic [2:0] op, logic z, logic [3:0] cnt);
    logic alu, jmp, sto, skz, e_ir, e_rd, e_wr, e_inc, e_lpc, e_lacc, e_dctl, e_halt;
    logic [3:0] ph;
    alu    = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    jmp    = (op == 3'd7);
    sto    = (op == 3'd6);
    skz    = (op == 3'd1);
    e_ir   = (pos == 0) || (pos == 1);
    e_rd   = e_ir || (alu && pos >= 4 && pos <= 6);
    e_wr   = sto && pos == 5;
    e_inc  = e_ir || (jmp && pos == 5) || (skz && z && (pos == 5 || pos == 7));
    e_lpc  = jmp && (pos == 4 || pos == 5);
    e_lacc = alu && pos == 5;
    e_dctl = sto && pos >= 4 && pos <= 6;
    e_halt = (pos == 9);
    ph     = pos[3:0];
    return {e_halt, e_ir, e_rd, e_wr, e_inc, e_lpc, e_lacc, e_dctl, ph, cnt};
  endfunction

  // One clock: drive inputs, advance the model across the edge, queue the expected outputs.
  task automatic cyc(input logic r, input logic rn, input logic [2:0] op, input logic z);
    rst    = r;
    run    = rn;
    opcode = (mpos == 2) ? op : 3'($urandom);
    zero   = (mpos == 2) ? z : 1'($urandom);
    if (r) begin
      mpos = 8; mcnt = 4'd0; mop = 3'b000; mz = 1'b0;
    end else begin
      case (mpos)
        8: mpos = rn ? 0 : 8;
        2: begin mop = op; mz = z; mpos = 3; end
        3: mpos = (mop == 3'b000) ? 9 : 4;
        7: begin mcnt = mcnt + 4'd1; mpos = rn ? 0 : 8; end
        9: mpos = 9;
        default: mpos = mpos + 1;
      endcase
    end
    @(posedge clk1);
    #2;
    exp_q.push_back(exp_vec(mpos, mop, mz, mcnt));
  endtask

  task automatic instr(input logic [2:0] op, input logic z);
    repeat (8) cyc(1'b0, 1'b1, op, z);
  endtask

  initial begin : monitor
    logic [15:0] got, want;
    forever begin
      @(negedge clk1);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {halt, ir_ena, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, phase, instr_cnt};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL outputs t=%0t got h/ir/rd/wr/inc/lpc/lacc/dctl=%b phase=%0d cnt=%0d required %b phase=%0d cnt=%0d",
                   $time, got[15:8], got[7:4], got[3:0], want[15:8], want[7:4], want[3:0]);
        end
      end
    end
  end

  initial begin : stimulus
    int halted_cycles;
    logic [2:0] rop;
    cyc(1'b1, 1'b1, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, 3'd0, 1'b0);
    instr(3'b101, 1'b0);
    instr(3'b001, 1'b1);
    instr(3'b001, 1'b0);
    instr(3'b110, 1'b0);
    for (int i = 0; i < 10 && mpos != 2; i++) cyc(1'b0, 1'b1, 3'b111, 1'b0);
    repeat (7) cyc(1'b0, 1'b0, 3'b111, 1'b0);
    for (int i = 0; i < 12 && mpos != 9; i++) cyc(1'b0, 1'b1, 3'b000, 1'b0);
    repeat (20) cyc(1'b0, 1'b1, 3'b000, 1'b0);
    cyc(1'b1, 1'b1, 3'b000, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b0);
    repeat (17) instr(3'b010, 1'b0);
    for (int i = 0; i < 10 && mpos != 8; i++) cyc(1'b0, 1'b0, 3'b010, 1'b0);
    halted_cycles = 0;
    for (int i = 0; i < 500; i++) begin
      rop = 3'($urandom);
      if (rop == 3'b000 && $urandom_range(0, 3) != 0) rop = 3'($urandom_range(1, 7));
      if (mpos == 9) halted_cycles++;
      if (halted_cycles >= 3) begin
        halted_cycles = 0;
        cyc(1'b1, 1'b1, rop, 1'b0);
      end else begin
        cyc($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0, rop, 1'($urandom));
      end
    end
    @(negedge clk1);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_sequencer.md
# risc_sequencer

Instruction-cycle controller for the RISC core. Runs a fixed 8-state fetch/execute sequence per instruction. Drives the instruction register's load enable across two byte fetches, decodes the latched 3-bit opcode, and issues the PC, accumulator, memory-read/write and data-bus-drive strobes for the rest of the core. Sits between the instruction register (opcode, zero flag in) and the PC, ALU/accumulator, memory and data-bus driver (strobes out).

## Interface
- CNT_W, 16, width of the retired-instruction counter
- clk1  in  1  core clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  permission to start a new instruction; sampled only in IDLE and S7
- opcode  in  3  instruction-register bits [15:13]; latched on the S2→S3 edge
- zero  in  1  accumulator-zero flag; latched on the S2→S3 edge
- ir_ena  out  1  load enable to the instruction register (one byte per asserted cycle)
- rd  out  1  memory read strobe
- wr  out  1  memory write strobe
- inc_pc  out  1  PC increment
- load_pc  out  1  PC load from instruction address field
- load_acc  out  1  accumulator load from ALU result
- datactl_ena  out  1  drive accumulator onto data bus
- halt  out  1  core halted (sticky until rst)
- phase  out  4  current state encoding: IDLE=8, S0..S7=0..7, HALTED=9
- instr_cnt  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W

## Operation
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111. ALUOP = ADD, AND, XOR, LDA.
- State transitions:
  - IDLE→S0 when run=1, else stay.
  - S0→S1→…→S7 unconditionally.
  - S3→HALTED if the latched opcode is HLT.
  - S7→S0 if run=1, else S7→IDLE.
  - HALTED→HALTED until rst.
- Outputs are Moore, decoded from current state plus latched opcode (op_q) and latched zero (zero_q). All outputs are 0 unless listed below.
  - S0: ir_ena, rd, inc_pc (high byte fetch).
  - S1: ir_ena, rd, inc_pc (low byte fetch).
  - S2: none.
  - S3: none. HLT leaves this state to HALTED.
  - S4: rd if ALUOP; load_pc if JMP; datactl_ena if STO.
  - S5: rd and load_acc if ALUOP; load_pc and inc_pc if JMP; inc_pc if SKZ and zero_q; wr and datactl_ena if STO.
  - S6: rd if ALUOP; datactl_ena if STO.
  - S7: inc_pc if SKZ and zero_q.
  - HALTED: halt=1, all strobes 0.
- instr_cnt increments by 1 on every S7 exit, wrapping from all-ones to 0. HLT does not count.
- op_q and zero_q hold their values from the S2→S3 edge through S7. Opcode/zero changes in S3..S7 have no effect.

## Timing
- Reset: state=IDLE, every strobe 0, halt=0, phase=8, instr_cnt=0, op_q=000, zero_q=0. Values are visible the cycle after the rst edge.
- rst asserted in any state, including mid-instruction or HALTED, aborts to IDLE at the next edge. Strobes are 0 from that edge.
- Latency: run=1 in IDLE gives ir_ena=1 the next cycle. One instruction takes exactly 8 cycles. Back-to-back instructions have no gap while run=1.
- Dropping run mid-instruction completes the current instruction. The sequencer then parks in IDLE after S7, and that instruction is still counted.
- The instruction register captures the high byte at the S0→S1 edge and the low byte at the S1→S2 edge. opcode is therefore stable before the S2→S3 latch.
- At most one of rd/wr is asserted in any cycle. load_pc implies opcode JMP.

## Test plan
- Reset: hold rst 2 cycles with run=1 → phase=8, all strobes 0, instr_cnt=0. Release → ir_ena=rd=inc_pc=1 in the first cycle after IDLE.
- LDA (101), run=1 → rd=1 in S4, S5 and S6; load_acc=1 only in S5; instr_cnt=1 after S7; the next cycle is S0.
- SKZ (001) with zero=1 → inc_pc=1 in S5 and S7 (4 PC increments total). Repeat with zero=0 → only the 2 fetch increments.
- STO (110) → datactl_ena=1 in S4, S5 and S6; wr=1 only in S5; rd never asserted after S1.
- HLT (000) → phase goes 0,1,2,3,9; halt=1 and stays 1 for 20 cycles with run=1; instr_cnt unchanged. Pulsing rst → IDLE, halt=0.
- run dropped in S2 of JMP (111) → load_pc=1 in S4 and S5, inc_pc=1 in S5; phase goes 7 then 8. With CNT_W preloaded near all-ones, running all-ones+1 instructions shows instr_cnt wrapping to 0.
